wb_tag_pipe: RTL and testbench
==============================

// Module: wb_tag_pipe
// PURPOSE
//  Producer of the destination-register tags consumed by the hazard detection unit.
//  Decodes rd/write-enable from the 16-bit instruction in ID and shifts them through EX/MEM/WB
//  in lockstep with the datapath.
//  Inserts bubbles on hazard stall or branch flush; holds EX during multi-cycle MUL.
//  Drives the register-file write port from the WB stage.
// PARAMETERS
//  MUL_LAT  3  total EX-stage cycles for MUL (opcode 4'b0011); 1 = single-cycle, no hold
//  CNT_W    2  width of MUL hold counter; must satisfy 2**CNT_W >= MUL_LAT
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  id_inst    in   16  instruction currently in ID
//  id_valid   in   1   id_inst is a real instruction (0 = bubble)
//  stall      in   1   hazard unit need_stall: ID held, bubble into EX
//  flush      in   1   branch taken in EX: ID instruction killed
//  ex_hold    out  1   EX occupied by MUL with cycles remaining; freezes PC, IF/ID, ID/EX
//  ex_rd      out  3   EX destination register
//  ex_wb_en   out  1   EX instruction will write ex_rd
//  mem_rd     out  3   MEM destination register
//  mem_wb_en  out  1   MEM instruction will write mem_rd
//  wb_rd      out  3   WB destination register; also register-file write address
//  wb_wb_en   out  1   WB instruction writes; also register-file write enable
// BEHAVIOUR
//  Decode in ID, combinational:
//   - opcode = id_inst[15:12]; rd = id_inst[11:9]
//   - writes when opcode <= 4'b1010 (ALU, ADDI, LW)
//   - no write for 4'b1011 (SW), 4'b1100 (BEQ), 4'b1101..4'b1111
//   - wb_en = id_valid & writes & (rd != 0); r0 never tagged
//  Reset: all rd = 3'd0, all wb_en = 0, hold counter = 0, ex_hold = 0.
//   Async assert clears mid-MUL; first edge after deassert behaves as an empty pipe.
//  Per rising edge, priority high to low:
//   1. ex_hold = 1:
//      - EX tag and counter-- hold; MEM <= bubble (rd 0, wb_en 0); WB <= old MEM
//      - flush and stall ignored
//   2. flush = 1: EX <= bubble; MEM <= old EX; WB <= old MEM
//   3. stall = 1: EX <= bubble; MEM <= old EX; WB <= old MEM
//   4. otherwise: EX <= decoded ID tag; MEM <= old EX; WB <= old MEM
//  MUL hold counter:
//   - loads MUL_LAT-1 when a valid MUL enters EX (case 4 only)
//   - decrements while nonzero
//   - ex_hold = (cnt != 0), registered output
//   - MUL_LAT = 1: counter never leaves 0
//  Latency: tag visible on ex_* one edge after acceptance; reaches wb_* two edges later,
//   plus MUL_LAT-1 for MUL.
//  Bubbles always carry rd = 0, wb_en = 0, so the hazard unit never matches them.
//  Back-to-back MULs: second MUL waits in ID (ex_hold freezes it). It loads the counter
//   on the edge the first MUL leaves EX; no idle EX cycle in between.
// STRUCTURE
//  Shared package/header:
//   - opcode constants (OP_MUL 4'b0011, OP_LW 4'b1010, OP_SW 4'b1011, OP_BEQ 4'b1100)
//   - field positions for opcode/rd
//   - REG_W = 3
//   The hazard unit uses the same constants.
//  Sub-module: rd_decode (combinational ID decode: id_inst, id_valid -> rd, wb_en, is_mul),
//   reusable by the forwarding unit.
//  Three tag flops plus the counter stay in wb_tag_pipe.
// TESTING
//  T1 reset: rst pulse mid-MUL (ex_hold=1) -> all outputs 0 immediately, before next clk edge.
//  T2 flow: ADDI r3 (16'h8_6_..: opcode 4'b1000, rd 3) then SW, no stall:
//     - ex_rd=3/ex_wb_en=1 after edge 1; mem after edge 2; wb_rd=3, wb_wb_en=1 after edge 3
//     - SW tags carry wb_en=0
//  T3 r0: ALU op with rd=0 -> wb_en 0 in all three stages.
//  T4 stall: stall=1 for 2 cycles while ID holds ADD r5:
//     - two bubbles enter EX
//     - ADD r5 enters EX on first edge with stall=0
//     - older tags drain to WB unaffected
//  T5 flush+stall same cycle with LW r2 in ID: EX <= bubble; LW r2 never reaches mem_wb_en.
//  T6 MUL r4, MUL_LAT=3:
//     - ex_hold=1 for exactly 2 cycles after MUL enters EX; MEM gets 2 bubbles
//     - flush asserted during hold is ignored
//     - mem_rd=4 on the edge after ex_hold falls

Source files
------------

// File: rtl/wb_tag_pipe_pkg.sv
// Shared constants and tag type for the destination-register tag pipeline.
// The hazard and forwarding units import the same definitions.
package wb_tag_pipe_pkg;

    localparam int unsigned REG_W = 3;

    // Instruction field positions
    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_MSB = 11;
    localparam int unsigned RD_LSB = 9;

    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wb_en;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    // Every opcode up to and including LW writes a register.
    function automatic logic op_writes(input logic [3:0] opcode);
        return opcode <= OP_LW;
    endfunction

endpackage

// File: rtl/rd_decode.sv
// Combinational ID-stage decode of destination register, write enable and MUL flag.
// Invalid (bubble) slots always decode to rd 0 with no write.
module rd_decode
    import wb_tag_pipe_pkg::*;
(
    input  logic [15:0]      id_inst,
    input  logic             id_valid,
    output logic [REG_W-1:0] rd,
    output logic             wb_en,
    output logic             is_mul
);

    logic [3:0]       opcode;
    logic [REG_W-1:0] rd_field;
    logic             unused_imm;

    assign opcode     = id_inst[OP_MSB:OP_LSB];
    assign rd_field   = id_inst[RD_MSB:RD_LSB];
    assign unused_imm = ^id_inst[RD_LSB-1:0];

    assign rd     = id_valid ? rd_field : '0;
    // r0 is hardwired, so it is never tagged as a write target.
    assign wb_en  = id_valid && op_writes(opcode) && (rd_field != '0);
    assign is_mul = id_valid && (opcode == OP_MUL);

endmodule

// File: rtl/wb_tag_pipe.sv
// EX/MEM/WB destination-register tag pipeline feeding the hazard unit and the
// register-file write port; holds EX for the duration of a multi-cycle MUL.
module wb_tag_pipe
    import wb_tag_pipe_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_inst,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_hold,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_wb_en,
    output logic [REG_W-1:0] mem_rd,
    output logic             mem_wb_en,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_wb_en
);

    tag_t             id_tag;
    logic             id_is_mul;
    tag_t             ex_q, ex_d;
    tag_t             mem_q, mem_d;
    tag_t             wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    rd_decode u_rd_decode (
        .id_inst (id_inst),
        .id_valid(id_valid),
        .rd      (id_tag.rd),
        .wb_en   (id_tag.wb_en),
        .is_mul  (id_is_mul)
    );

    assign ex_hold = (cnt_q != '0);

    always_comb begin
        ex_d  = ex_q;
        mem_d = ex_q;
        wb_d  = mem_q;
        cnt_d = cnt_q;
        if (ex_hold) begin
            // MUL still busy: EX frozen, MEM sees bubbles, stall/flush ignored.
            mem_d = TAG_BUBBLE;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (flush || stall) begin
            ex_d = TAG_BUBBLE;
        end else begin
            ex_d = id_tag;
            if (id_is_mul && (MUL_LAT > 1)) begin
                cnt_d = CNT_W'(MUL_LAT - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= TAG_BUBBLE;
            mem_q <= TAG_BUBBLE;
            wb_q  <= TAG_BUBBLE;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_rd     = ex_q.rd;
    assign ex_wb_en  = ex_q.wb_en;
    assign mem_rd    = mem_q.rd;
    assign mem_wb_en = mem_q.wb_en;
    assign wb_rd     = wb_q.rd;
    assign wb_wb_en  = wb_q.wb_en;

endmodule

// File: tb/tb_wb_tag_pipe.sv
// Testbench for wb_tag_pipe: directed vector table, random scoreboard stream,
// and asynchronous reset during a MUL hold.
module tb_wb_tag_pipe;

    logic        clk;
    logic        rst;
    logic [15:0] id_inst;
    logic        id_valid;
    logic        stall;
    logic        flush;
    logic        ex_hold;
    logic [2:0]  ex_rd;
    logic        ex_wb_en;
    logic [2:0]  mem_rd;
    logic        mem_wb_en;
    logic [2:0]  wb_rd;
    logic        wb_wb_en;

    int n_checks = 0;
    int n_pass   = 0;

    wb_tag_pipe #(
        .MUL_LAT(3),
        .CNT_W  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .id_inst  (id_inst),
        .id_valid (id_valid),
        .stall    (stall),
        .flush    (flush),
        .ex_hold  (ex_hold),
        .ex_rd    (ex_rd),
        .ex_wb_en (ex_wb_en),
        .mem_rd   (mem_rd),
        .mem_wb_en(mem_wb_en),
        .wb_rd    (wb_rd),
        .wb_wb_en (wb_wb_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tags are compared as {rd, wb_en}.
    typedef struct {
        logic [15:0] inst;
        logic        valid;
        logic        stall;
        logic        flush;
        logic        hold;
        logic [3:0]  ex;
        logic [3:0]  mem;
        logic [3:0]  wb;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] inst, input logic v, input logic s, input logic f);
        id_inst  = inst;
        id_valid = v;
        stall    = s;
        flush    = f;
    endtask

    function automatic vec_t mk(input logic [15:0] inst, input logic v, input logic s,
                                input logic f, input logic h, input logic [3:0] e,
                                input logic [3:0] m, input logic [3:0] w);
        vec_t r;
        r.inst = inst; r.valid = v; r.stall = s; r.flush = f;
        r.hold = h; r.ex = e; r.mem = m; r.wb = w;
        return r;
    endfunction

    // Independent reference decode for the random stream.
    function automatic logic [3:0] ref_tag(input logic [15:0] inst);
        logic [3:0] op;
        logic [2:0] rd;
        op = inst[15:12];
        rd = inst[11:9];
        return {rd, (op <= 4'd10) && (rd != 3'd0)};
    endfunction

    initial begin
        logic [3:0] q[$];
        logic [3:0] exp_t;
        logic [15:0] inst;
        logic s, f;

        // Directed table: ADDI r3=8600, SW=B000, ALU r0=1000, ADD r5=0A00,
        // LW r2=A400, MUL r4=3800, MUL r5=3A00.
        vecs[0]  = mk(16'h8600, 1, 0, 0, 0, 4'h7, 4'h0, 4'h0);
        vecs[1]  = mk(16'hB000, 1, 0, 0, 0, 4'h0, 4'h7, 4'h0);
        vecs[2]  = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'h7);
        vecs[3]  = mk(16'h1000, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        vecs[4]  = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        vecs[5]  = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        vecs[6]  = mk(16'h8600, 1, 0, 0, 0, 4'h7, 4'h0, 4'h0);
        vecs[7]  = mk(16'h0A00, 1, 1, 0, 0, 4'h0, 4'h7, 4'h0);
        vecs[8]  = mk(16'h0A00, 1, 1, 0, 0, 4'h0, 4'h0, 4'h7);
        vecs[9]  = mk(16'h0A00, 1, 0, 0, 0, 4'hB, 4'h0, 4'h0);
        vecs[10] = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'hB, 4'h0);
        vecs[11] = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'hB);
        vecs[12] = mk(16'h8600, 1, 0, 0, 0, 4'h7, 4'h0, 4'h0);
        vecs[13] = mk(16'hA400, 1, 1, 1, 0, 4'h0, 4'h7, 4'h0);
        vecs[14] = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'h7);
        vecs[15] = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        vecs[16] = mk(16'h3800, 1, 0, 0, 1, 4'h9, 4'h0, 4'h0);
        vecs[17] = mk(16'h8600, 1, 0, 1, 1, 4'h9, 4'h0, 4'h0);
        vecs[18] = mk(16'h8600, 1, 0, 1, 0, 4'h9, 4'h0, 4'h0);
        vecs[19] = mk(16'h8600, 1, 0, 0, 0, 4'h7, 4'h9, 4'h0);
        vecs[20] = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'h7, 4'h9);
        vecs[21] = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'h7);
        vecs[22] = mk(16'h3800, 1, 0, 0, 1, 4'h9, 4'h0, 4'h0);
        vecs[23] = mk(16'h3A00, 1, 0, 0, 1, 4'h9, 4'h0, 4'h0);
        vecs[24] = mk(16'h3A00, 1, 0, 0, 0, 4'h9, 4'h0, 4'h0);
        vecs[25] = mk(16'h3A00, 1, 0, 0, 1, 4'hB, 4'h9, 4'h0);
        vecs[26] = mk(16'h0000, 0, 0, 0, 1, 4'hB, 4'h0, 4'h9);
        vecs[27] = mk(16'h0000, 0, 0, 0, 0, 4'hB, 4'h0, 4'h0);
        vecs[28] = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'hB, 4'h0);
        vecs[29] = mk(16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'hB);

        rst = 1'b1;
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_hold", {3'b0, ex_hold}, 4'h0);
        check("reset_ex", {ex_rd, ex_wb_en}, 4'h0);
        check("reset_mem", {mem_rd, mem_wb_en}, 4'h0);
        check("reset_wb", {wb_rd, wb_wb_en}, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].inst, vecs[i].valid, vecs[i].stall, vecs[i].flush);
            tick();
            check($sformatf("vec%0d_hold", i), {3'b0, ex_hold}, {3'b0, vecs[i].hold});
            check($sformatf("vec%0d_ex", i), {ex_rd, ex_wb_en}, vecs[i].ex);
            check($sformatf("vec%0d_mem", i), {mem_rd, mem_wb_en}, vecs[i].mem);
            check($sformatf("vec%0d_wb", i), {wb_rd, wb_wb_en}, vecs[i].wb);
        end

        // Random non-MUL stream with stall/flush bubbles, scoreboarded to WB.
        for (int c = 0; c < 200; c++) begin
            inst = 16'($urandom());
            if (inst[15:12] == 4'b0011) inst[15:12] = 4'b0100;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            drive(inst, 1'b1, s, f);
            q.push_back((s || f) ? 4'h0 : ref_tag(inst));
            tick();
            check("sb_ex", {ex_rd, ex_wb_en}, q[q.size()-1]);
            if (q.size() == 3) begin
                check("sb_mem", {mem_rd, mem_wb_en}, q[1]);
                exp_t = q.pop_front();
                check("sb_wb", {wb_rd, wb_wb_en}, exp_t);
            end
        end

        // Asynchronous reset while a MUL holds EX.
        drive(16'h3800, 1'b1, 1'b0, 1'b0);
        tick();
        check("rst_pre_hold", {3'b0, ex_hold}, 4'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_hold", {3'b0, ex_hold}, 4'h0);
        check("rst_async_ex", {ex_rd, ex_wb_en}, 4'h0);
        check("rst_async_mem", {mem_rd, mem_wb_en}, 4'h0);
        check("rst_async_wb", {wb_rd, wb_wb_en}, 4'h0);
        rst = 1'b0;
        drive(16'h8600, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_rst_hold", {3'b0, ex_hold}, 4'h0);
        check("post_rst_ex", {ex_rd, ex_wb_en}, 4'h7);
        check("post_rst_mem", {mem_rd, mem_wb_en}, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
